// File: rtl/pred_issue_pkg.sv
// Shared types for the predicated issue core: FSM states, opcodes, instruction field positions.
package pred_issue_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_FETCH = 2'd1,
        S_READ  = 2'd2,
        S_LOAD  = 2'd3
    } state_e;

    typedef enum logic [4:0] {
        OP_LOAD    = 5'd0,
        OP_STORE   = 5'd1,
        OP_MUL     = 5'd2,
        OP_ADD     = 5'd3,
        OP_SUB     = 5'd4,
        OP_SHR     = 5'd5,
        OP_SHL     = 5'd6,
        OP_AND     = 5'd7,
        OP_NOT     = 5'd8,
        OP_XOR     = 5'd9,
        OP_OR      = 5'd10,
        OP_NAND    = 5'd11,
        OP_LDI     = 5'd12,
        OP_SETP    = 5'd13,
        OP_QPUSH_R = 5'd14,
        OP_QPUSH_I = 5'd15,
        OP_HALT    = 5'd16
    } opcode_e;

    localparam int PRED_MSB = 31;
    localparam int PRED_LSB = 30;
    localparam int TYPE_BIT = 29;
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 24;
    localparam int RA_MSB   = 23;
    localparam int RA_LSB   = 20;
    localparam int RB_MSB   = 19;
    localparam int RB_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 12;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    // Destination register select: shifts/NOT/LOAD write back into ra, LDI into rb.
    function automatic logic [3:0] target_reg(input logic [4:0] op, input logic [3:0] ra,
                                              input logic [3:0] rb, input logic [3:0] rd);
        case (op)
            OP_LOAD, OP_SHR, OP_SHL, OP_NOT: return ra;
            OP_LDI:                          return rb;
            default:                         return rd;
        endcase
    endfunction

endpackage

// File: rtl/pred_issue_alu.sv
// Combinational ALU for the issue core plus the unsigned SETP compare.
// The multiplier only exists when PRED_ISSUE_MUL_EN is defined.
module pred_issue_alu
    import pred_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] result,
    output logic              lt
);

    logic shift_over;

    assign shift_over = (imm >= 16'(DATA_W));
    assign lt         = (a < b);

    always_comb begin
        result = '0;
        case (op)
`ifdef PRED_ISSUE_MUL_EN
            OP_MUL:  result = a * b;
`endif
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SHR:  result = shift_over ? '0 : (a >> imm[5:0]);
            OP_SHL:  result = shift_over ? '0 : (a << imm[5:0]);
            OP_AND:  result = a & b;
            OP_NOT:  result = ~a;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_NAND: result = ~(a & b);
            OP_LDI:  result = DATA_W'(imm);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/pred_issue_core.sv
// Predicated single-issue core: fetch, predicate check, execute/writeback, load and store/push handshakes.
// Define PRED_ISSUE_MUL_EN to make opcode 2 a multiply; otherwise it retires as a NOP.
//
// state   | meaning
// S_REQ   | idle, request_pc high, waiting for set_pc
// S_FETCH | curr_pc presented, waiting for instr_valid
// S_READ  | operands read, execute or hold for mem_w_ready / q_ready
// S_LOAD  | write back mem_rdata returned for the load issued in S_READ
module pred_issue_core
    import pred_issue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 16,
    parameter int NUM_PRED = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_pc,
    input  logic [PC_W-1:0]   new_pc,
    output logic              request_pc,
    output logic [PC_W-1:0]   curr_pc,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic [3:0]        r_reg0,
    output logic [3:0]        r_reg1,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    output logic              reg_we,
    output logic [3:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [PC_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [PC_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_w_ready,
    output logic              q_we,
    output logic [3:0]        q_num,
    input  logic              q_ready
);

    state_e                state;
    state_e                state_nxt;
    logic [PC_W-1:0]       pc;
    logic [31:0]           ir;
    logic [NUM_PRED-1:1]   pred_q;
    logic [3:0]            pred_view;

    logic [1:0]            pf;
    logic [4:0]            op;
    logic [3:0]            ra;
    logic [3:0]            rb;
    logic [3:0]            rd;
    logic [15:0]           imm;
    logic [3:0]            tgt;
    logic                  pred_ok;
    logic                  pc_adv;
    logic                  pred_we;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_lt;
    logic                  unused_type;

    assign pf          = ir[PRED_MSB:PRED_LSB];
    assign op          = ir[OP_MSB:OP_LSB];
    assign ra          = ir[RA_MSB:RA_LSB];
    assign rb          = ir[RB_MSB:RB_LSB];
    assign rd          = ir[RD_MSB:RD_LSB];
    assign imm         = ir[IMM_MSB:IMM_LSB];
    assign unused_type = ir[TYPE_BIT];
    assign tgt         = target_reg(op, ra, rb, rd);

    assign r_reg0    = ra;
    assign r_reg1    = rb;
    assign curr_pc   = pc;
    assign mem_raddr = rdata0[PC_W-1:0];

    // p0 is hard-wired true; indices at or above NUM_PRED read false.
    always_comb begin
        pred_view    = 4'b0001;
        for (int i = 1; i < NUM_PRED; i++) begin
            pred_view[i] = pred_q[i];
        end
        pred_ok = pred_view[pf];
    end

    pred_issue_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (rdata0),
        .b      (rdata1),
        .imm    (imm),
        .result (alu_result),
        .lt     (alu_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            ir     <= '0;
            pred_q <= '0;
        end else begin
            if (state == S_REQ && set_pc) begin
                pc <= new_pc;
            end else if (pc_adv) begin
                pc <= pc + PC_W'(1);
            end
            if (state == S_FETCH && instr_valid) begin
                ir <= instr;
            end
            for (int i = 1; i < NUM_PRED; i++) begin
                if (pred_we && tgt[1:0] == 2'(i)) begin
                    pred_q[i] <= alu_lt;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (set_pc) state_nxt = S_FETCH;
            S_FETCH: if (instr_valid) state_nxt = S_READ;
            S_READ: begin
                if (!pred_ok) begin
                    state_nxt = S_FETCH;
                end else begin
                    case (op)
                        OP_LOAD:    state_nxt = S_LOAD;
                        OP_STORE:   if (mem_w_ready) state_nxt = S_FETCH;
                        OP_QPUSH_R,
                        OP_QPUSH_I: if (q_ready) state_nxt = S_FETCH;
                        OP_HALT:    state_nxt = S_REQ;
                        default:    state_nxt = S_FETCH;
                    endcase
                end
            end
            S_LOAD:  state_nxt = S_FETCH;
            default: state_nxt = S_REQ;
        endcase
    end

    // Data outputs are left driven from the decode; only the enables are gated by state.
    always_comb begin
        request_pc = (state == S_REQ);
        reg_we     = 1'b0;
        reg_waddr  = tgt;
        reg_wdata  = alu_result;
        mem_we     = 1'b0;
        mem_waddr  = rdata1[PC_W-1:0];
        mem_wdata  = rdata0;
        q_we       = 1'b0;
        q_num      = (op == OP_QPUSH_I) ? imm[3:0] : rdata0[3:0];
        pc_adv     = 1'b0;
        pred_we    = 1'b0;
        case (state)
            S_READ: begin
                if (!pred_ok) begin
                    pc_adv = 1'b1;
                end else if (op == OP_STORE) begin
                    mem_we = 1'b1;
                    pc_adv = mem_w_ready;
                end else if (op == OP_QPUSH_R || op == OP_QPUSH_I) begin
                    q_we   = 1'b1;
                    pc_adv = q_ready;
                end else if (op == OP_LOAD || op == OP_HALT) begin
                    pc_adv = 1'b0;
                end else if (op == OP_SETP) begin
                    pred_we = 1'b1;
                    pc_adv  = 1'b1;
                end else if (op == OP_MUL) begin
`ifdef PRED_ISSUE_MUL_EN
                    reg_we = 1'b1;
`endif
                    pc_adv = 1'b1;
                end else if (op >= OP_ADD && op <= OP_LDI) begin
                    reg_we = 1'b1;
                    pc_adv = 1'b1;
                end else begin
                    pc_adv = 1'b1;
                end
            end
            S_LOAD: begin
                reg_we    = 1'b1;
                reg_wdata = mem_rdata;
                pc_adv    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
